// File: rtl/prog_clk_div.sv
// Programmable clock divider: counts enabled cycles modulo a runtime divisor D,
// producing a square wave (mode 0) or a one-cycle pulse (mode 1), with divisor
// reloads deferred to the next period boundary so no output period is truncated.
module prog_clk_div #(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_mode,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pend,
    output logic             div_err,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] d_reg;
    logic             m_reg;
    logic [WIDTH-1:0] pend_d;
    logic             pend_m;

    logic             load_ok_c;
    logic             terminal_c;
    logic [WIDTH-1:0] new_d_c;
    logic             new_m_c;

    // Load qualification, period boundary, and the divisor/mode taking effect there
    always_comb begin
        load_ok_c  = div_load && (div_val != '0);
        // >= keeps the counter bounded even if D shrinks under it
        terminal_c = (count >= (d_reg - ONE));
        new_d_c    = d_reg;
        new_m_c    = m_reg;
        if (load_ok_c) begin
            new_d_c = div_val;
            new_m_c = div_mode;
        end else if (div_pend) begin
            new_d_c = pend_d;
            new_m_c = pend_m;
        end
    end

    // Counter, divisor/mode, pending request and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            d_reg    <= DIV_RST;
            m_reg    <= 1'b0;
            pend_d   <= '0;
            pend_m   <= 1'b0;
            div_pend <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            div_err <= div_load && (div_val == '0);
            if (en) begin
                if (terminal_c) begin
                    count    <= '0;
                    tick     <= 1'b1;
                    div_pend <= 1'b0;
                    d_reg    <= new_d_c;
                    m_reg    <= new_m_c;
                    // Pulse mode wins; otherwise an outgoing square wave toggles
                    // and an outgoing pulse stream leaves the level where it is
                    if (new_m_c) begin
                        clk_out <= 1'b1;
                    end else if (!m_reg) begin
                        clk_out <= ~clk_out;
                    end
                end else begin
                    count <= count + ONE;
                    tick  <= 1'b0;
                    if (m_reg) begin
                        clk_out <= 1'b0;
                    end
                    if (load_ok_c) begin
                        pend_d   <= div_val;
                        pend_m   <= div_mode;
                        div_pend <= 1'b1;
                    end
                end
            end else begin
                tick <= 1'b0;
                if (m_reg) begin
                    clk_out <= 1'b0;
                end
                // With counting stalled there is no period to protect: apply now
                if (load_ok_c) begin
                    d_reg    <= div_val;
                    m_reg    <= div_mode;
                    count    <= '0;
                    div_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div with WIDTH=8, DEFAULT_DIV=4.
module tb_prog_clk_div;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             div_mode;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_pend;
    logic             div_err;
    logic [WIDTH-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    prog_clk_div #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div_val  (div_val),
        .div_mode (div_mode),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_pend (div_pend),
        .div_err  (div_err),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before inputs change or outputs are sampled
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_cnt, input int e_tick,
                           input int e_clk, input int e_pend, input int e_err);
        chk({tag, ".count"},    int'(count),    e_cnt);
        chk({tag, ".tick"},     int'(tick),     e_tick);
        chk({tag, ".clk_out"},  int'(clk_out),  e_clk);
        chk({tag, ".div_pend"}, int'(div_pend), e_pend);
        chk({tag, ".div_err"},  int'(div_err),  e_err);
    endtask

    task automatic load(input int v, input logic m);
        div_load = 1'b1;
        div_val  = WIDTH'(v);
        div_mode = m;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; div_val = '0; div_mode = 1'b0; div_load = 1'b0;
        cyc(); cyc();
        chk_all("reset", 0, 0, 0, 0, 0);

        // Free-running with default divisor 4
        reset = 1'b0; en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk_all("run4", i % 4, (i % 4 == 0) ? 1 : 0, (i / 4) % 2, 0, 0);
        end

        // Zero divisor rejected: one-cycle error, period unchanged
        load(0, 1'b1);
        cyc(); chk_all("err0", 1, 0, 0, 0, 1);
        div_load = 1'b0;
        cyc(); chk_all("err1", 2, 0, 0, 0, 0);
        cyc(); chk_all("err2", 3, 0, 0, 0, 0);
        cyc(); chk_all("err3", 0, 1, 1, 0, 0);

        // Stall at count 2 for five cycles
        cyc(); cyc(); chk_all("pre_stall", 2, 0, 1, 0, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); chk_all("stall", 2, 0, 1, 0, 0);
        end
        en = 1'b1;
        cyc(); chk_all("resume1", 3, 0, 1, 0, 0);
        cyc(); chk_all("resume2", 0, 1, 0, 0, 0);

        // Deferred load at count 1: D=3, pulse mode, applied at the wrap
        cyc(); chk_all("pl_c1", 1, 0, 0, 0, 0);
        load(3, 1'b1);
        cyc(); chk_all("pl_c2", 2, 0, 0, 1, 0);
        div_load = 1'b0;
        cyc(); chk_all("pl_c3", 3, 0, 0, 1, 0);
        cyc(); chk_all("pl_apply", 0, 1, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk_all("pulse3", i % 3, (i % 3 == 0) ? 1 : 0, (i % 3 == 0) ? 1 : 0, 0, 0);
        end

        // Immediate load while stalled: back to D=4 toggle; pulse output drops
        en = 1'b0; load(4, 1'b0);
        cyc(); chk_all("imm4", 0, 0, 0, 0, 0);
        div_load = 1'b0; en = 1'b1;
        cyc(); cyc(); cyc(); chk_all("to_c3", 3, 0, 0, 0, 0);

        // Load coincident with terminal edge: applied at once, no pending
        load(6, 1'b0);
        cyc(); chk_all("coinc", 0, 1, 1, 0, 0);
        div_load = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk_all("run6", i % 6, (i == 6) ? 1 : 0, (i == 6) ? 0 : 1, 0, 0);
        end

        // Stalled load of 5 mid-period restarts count at 0
        cyc(); cyc(); chk_all("pre5", 2, 0, 0, 0, 0);
        en = 1'b0; load(5, 1'b0);
        cyc(); chk_all("imm5", 0, 0, 0, 0, 0);
        div_load = 1'b0; en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk_all("run5", i % 5, (i == 5) ? 1 : 0, (i == 5) ? 1 : 0, 0, 0);
        end

        // D=1 pulse mode: tick and clk_out constantly high
        en = 1'b0; load(1, 1'b1);
        cyc(); chk_all("imm1p", 0, 0, 1, 0, 0);
        div_load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_all("d1pulse", 0, 1, 1, 0, 0);
        end

        // D=1 toggle mode: clk/2
        en = 1'b0; load(1, 1'b0);
        cyc(); chk_all("imm1t", 0, 0, 0, 0, 0);
        div_load = 1'b0; en = 1'b1;
        cyc(); chk_all("d1t_a", 0, 1, 1, 0, 0);
        cyc(); chk_all("d1t_b", 0, 1, 0, 0, 0);

        // Build pending state with clk_out high, then reset over it
        en = 1'b0; load(4, 1'b0);
        cyc(); chk_all("imm4b", 0, 0, 0, 0, 0);
        div_load = 1'b0; en = 1'b1;
        cyc(); cyc(); cyc(); cyc(); chk_all("wrap4", 0, 1, 1, 0, 0);
        cyc(); chk_all("c1", 1, 0, 1, 0, 0);
        load(2, 1'b1);
        cyc(); chk_all("pend_set", 2, 0, 1, 1, 0);
        reset = 1'b1; load(7, 1'b1);
        cyc(); chk_all("rst_mid", 0, 0, 0, 0, 0);
        reset = 1'b0; div_load = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk_all("post_rst", i % 4, (i % 4 == 0) ? 1 : 0, (i / 4) % 2, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 Parameter: WIDTH, 26, bit width of divisor and counter.
REQ-002 Parameter: DEFAULT_DIV, 50000000, divisor after reset; SHALL satisfy 1 <= DEFAULT_DIV <= 2^WIDTH-1.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  count enable; counter advances only when high.
REQ-006 Port: div_val  input  WIDTH  requested divisor, sampled when div_load=1.
REQ-007 Port: div_mode  input  1  requested output mode, sampled with div_load; 0=toggle (square wave), 1=pulse.
REQ-008 Port: div_load  input  1  single-cycle request to load div_val/div_mode.
REQ-009 Port: clk_out  output  1  registered divided output.
REQ-010 Port: tick  output  1  registered one-cycle pulse, once per D enabled cycles.
REQ-011 Port: div_pend  output  1  high while an accepted load awaits application.
REQ-012 Port: div_err  output  1  one-cycle pulse when a load is rejected.
REQ-013 Port: count  output  WIDTH  current counter value, for observability.

Function
REQ-014 Active divisor D and mode M registers; counter runs 0..D-1.
REQ-015 Edge with en=1 and count<D-1: count<=count+1, tick<=0.
REQ-016 Terminal edge (en=1, count==D-1): count<=0, tick<=1 for exactly the next cycle.
REQ-017 M=0: clk_out toggles on every terminal edge; output period 2*D cycles, 50% duty.
REQ-018 M=1: clk_out<=1 on terminal edge, else 0; clk_out equals tick; period D cycles.
REQ-019 D=1 legal: M=0 gives clk/2, M=1 gives clk_out/tick constantly high while en=1.
REQ-020 en=0: count and D held, tick<=0; M=0 clk_out holds value; M=1 clk_out<=0.
REQ-021 div_load with div_val==0: load rejected; div_err<=1 next cycle; D, M, pending state unchanged.
REQ-022 Valid div_load while en=1: div_val/div_mode captured into pending regs, div_pend<=1.
REQ-023 Pending load applied on next terminal edge: D, M <= pending, count<=0, div_pend<=0; the new period starts at that edge.
REQ-024 At application edge, tick<=1; clk_out toggles if the outgoing M=0, or follows REQ-018 if the new M=1.
REQ-025 div_load coincident with terminal edge: the new value is applied at that same edge; div_pend never asserts.
REQ-026 div_load while pending: pending regs overwritten; latest valid request wins.
REQ-027 Valid div_load while en=0: applied immediately on that edge (D, M updated, count<=0, tick<=0); div_pend stays 0.
REQ-028 Switching to M=0: clk_out continues from its current value; no forced level.
REQ-029 All outputs registered; no combinational path from inputs to outputs.
REQ-030 Counter never exceeds D-1; no wrap past 2^WIDTH-1.

Reset
REQ-031 reset=1 at a rising edge SHALL set: count=0, D=DEFAULT_DIV, M=0, pending cleared, clk_out=0, tick=0, div_pend=0, div_err=0.
REQ-032 reset SHALL override en and div_load on the same edge; a load requested during reset is discarded.
REQ-033 Reset mid-period or while pending SHALL abandon the period and the pending load.

Verification (WIDTH=8, DEFAULT_DIV=4)
REQ-034 Reset, then en=1, no loads -> count 0,1,2,3,0...; tick high 1 cycle in 4; clk_out toggles every 4 cycles (period 8).
REQ-035 At count=1 pulse div_load, div_val=3, div_mode=1 -> div_pend=1 until wrap after count=3; then tick=clk_out, high 1 cycle in 3.
REQ-036 div_load with div_val=0 -> div_err high exactly 1 cycle; period stays 4; div_pend stays 0.
REQ-037 At count=2 drop en for 5 cycles -> count held at 2, tick=0, clk_out held; resume: tick 2 cycles after en returns.
REQ-038 div_load div_val=6 on the count=3 edge -> no div_pend; next ticks 6 cycles apart. With en=0, div_val=5 -> count=0 next edge, D=5.
REQ-039 Assert reset with div_pend=1 and clk_out=1 -> next cycle all outputs 0, D=4, M=0; old pending never applied.
